// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: MSB-first frames with ready/valid intake and a done pulse.
// Optional even-parity trailer bit is built when the PISO_PARITY_EN macro is defined.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             so,
  output logic             frame,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   shreg_r, shreg_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               par_r, par_s;
  logic               so_r, so_s;
  logic               frame_r, frame_s;
  logic               done_r, done_s;
  logic               final_s;
  logic               ready_s;
  logic               accept_s;
  logic               load_s;

  // Final frame cycle: the last data bit, or the parity bit when the trailer is built.
`ifdef PISO_PARITY_EN
  assign final_s = (state_r == PAR);
`else
  assign final_s = (state_r == SHIFT) && (cnt_r == CNT_ZERO);
`endif

  assign ready_s  = !rst && ((state_r == IDLE) || final_s);
  assign accept_s = valid && ready_s;
  assign ready    = ready_s;
  assign so       = so_r;
  assign frame    = frame_r;
  assign done     = done_r;

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    par_s   = par_r;
    so_s    = 1'b0;
    frame_s = 1'b0;
    done_s  = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r > CNT_LAST) begin
          state_s = IDLE;
        end else if (cnt_r != CNT_ZERO) begin
          so_s    = shreg_r[WIDTH-1];
          shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
          cnt_s   = cnt_r - CNT_ONE;
          frame_s = 1'b1;
`ifdef PISO_PARITY_EN
          done_s  = 1'b0;
`else
          done_s  = (cnt_r == CNT_ONE);
`endif
        end else begin
`ifdef PISO_PARITY_EN
          state_s = PAR;
          so_s    = par_r;
          frame_s = 1'b1;
          done_s  = 1'b1;
`else
          if (accept_s) begin
            load_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
    // A new word puts its MSB on the line right away; the rest waits in the shifter.
    if (load_s) begin
      state_s = SHIFT;
      shreg_s = {data_in[WIDTH-2:0], 1'b0};
      cnt_s   = CNT_LAST;
      par_s   = even_parity(data_in);
      so_s    = data_in[WIDTH-1];
      frame_s = 1'b1;
      done_s  = 1'b0;
    end else begin
      par_s = par_s;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= '0;
      cnt_r   <= CNT_ZERO;
      par_r   <= 1'b0;
      so_r    <= 1'b0;
      frame_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      par_r   <= par_s;
      so_r    <= so_s;
      frame_r <= frame_s;
      done_r  <= done_s;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=8); frame length follows PISO_PARITY_EN.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       so;
  logic       frame;
  logic       done;

  int errors = 0;
  int checks = 0;

  piso_tx #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
    .ready(ready), .so(so), .frame(frame), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected serial bit in frame cycle k (1-based): data MSB first, then even parity.
  function automatic logic exp_bit(input logic [7:0] w, input int k);
    logic [7:0] t;
    t = w;
    if (k <= 8) return t[8-k];
    return ^t;
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if ({so, frame, done} !== 3'b000) begin errors++; $display("FAIL reset_outs got=%b exp=000", {so, frame, done}); end
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", ready); end
    checks++; if ({so, frame, done} !== 3'b000) begin errors++; $display("FAIL reset_outs_after got=%b exp=000", {so, frame, done}); end
  endtask

  task automatic test_basic(input logic [7:0] w);
    valid = 1'b1; data_in = w;
    @(negedge clk);
    valid = 1'b0; data_in = 8'h00;
    for (int k = 1; k <= FL; k++) begin
      checks++; if (so !== exp_bit(w, k)) begin errors++; $display("FAIL basic_so w=%h cyc=%0d got=%b exp=%b", w, k, so, exp_bit(w, k)); end
      checks++; if (frame !== 1'b1) begin errors++; $display("FAIL basic_frame w=%h cyc=%0d got=%b exp=1", w, k, frame); end
      checks++; if (done !== (k == FL)) begin errors++; $display("FAIL basic_done w=%h cyc=%0d got=%b exp=%b", w, k, done, (k == FL)); end
      checks++; if (ready !== (k == FL)) begin errors++; $display("FAIL basic_ready w=%h cyc=%0d got=%b exp=%b", w, k, ready, (k == FL)); end
      @(negedge clk);
    end
    checks++; if ({so, frame, done, ready} !== 4'b0001) begin errors++; $display("FAIL basic_tail w=%h got=%b exp=0001", w, {so, frame, done, ready}); end
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; data_in = 8'hA5;
    @(negedge clk);
    data_in = 8'h3C;
    for (int k = 1; k <= 2 * FL; k++) begin
      if (k == FL + 1) valid = 1'b0;
      checks++; if (so !== exp_bit((k <= FL) ? 8'hA5 : 8'h3C, (k <= FL) ? k : k - FL)) begin
        errors++; $display("FAIL b2b_so cyc=%0d got=%b", k, so);
      end
      checks++; if (frame !== 1'b1) begin errors++; $display("FAIL b2b_frame cyc=%0d got=%b exp=1", k, frame); end
      checks++; if (done !== (k == FL || k == 2 * FL)) begin errors++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, done, (k == FL || k == 2 * FL)); end
      @(negedge clk);
    end
    checks++; if ({so, frame, done} !== 3'b000) begin errors++; $display("FAIL b2b_tail got=%b exp=000", {so, frame, done}); end
  endtask

  task automatic test_ignore();
    valid = 1'b1; data_in = 8'h00;
    @(negedge clk);
    data_in = 8'hFF;
    for (int k = 1; k <= FL; k++) begin
      if (k == FL) valid = 1'b0;
      checks++; if (so !== 1'b0) begin errors++; $display("FAIL ignore_so cyc=%0d got=%b exp=0", k, so); end
      checks++; if (ready !== (k == FL)) begin errors++; $display("FAIL ignore_ready cyc=%0d got=%b exp=%b", k, ready, (k == FL)); end
      @(negedge clk);
    end
    checks++; if ({so, frame, done} !== 3'b000) begin errors++; $display("FAIL ignore_tail got=%b exp=000", {so, frame, done}); end
  endtask

  task automatic test_abort();
    valid = 1'b1; data_in = 8'hF0;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if ({so, frame} !== 2'b11) begin errors++; $display("FAIL abort_pre cyc=%0d got=%b exp=11", k, {so, frame}); end
      if (k == 3) rst = 1'b1;
      @(negedge clk);
    end
    checks++; if ({so, frame, done, ready} !== 4'b0000) begin errors++; $display("FAIL abort_rst got=%b exp=0000", {so, frame, done, ready}); end
    rst = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      checks++; if ({so, frame, done, ready} !== 4'b0001) begin errors++; $display("FAIL abort_after cyc=%0d got=%b exp=0001", k, {so, frame, done, ready}); end
    end
  endtask

  task automatic test_idle();
    valid = 1'b0; data_in = 8'h5A;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if ({so, frame, done, ready} !== 4'b0001) begin errors++; $display("FAIL idle cyc=%0d got=%b exp=0001", k, {so, frame, done, ready}); end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data_in = 8'h00;
    test_reset();
    test_idle();
    test_basic(8'hA5);
    test_basic(8'h07);
    test_basic(8'h80);
    test_back_to_back();
    test_ignore();
    test_abort();
    test_basic(8'h3C);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, default 8, parallel word width in bits; the block SHALL support WIDTH >= 2.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: data_in  input  WIDTH  parallel word to transmit, sampled only on accept.
REQ-005 Port: valid  input  1  producer offers data_in this cycle.
REQ-006 Port: ready  output  1  block can accept a word this cycle; accept = valid && ready at a clk edge.
REQ-007 Port: so  output  1  serial data out, MSB first, registered.
REQ-008 Port: frame  output  1  high on every cycle where so carries a frame bit, registered.
REQ-009 Port: done  output  1  one-cycle pulse on the last bit cycle of a frame, registered.

Function
REQ-010 FSM states SHALL be IDLE, SHIFT and PAR; PAR is present only when PISO_PARITY_EN is defined.
REQ-011 In IDLE: so=0, frame=0, done=0, ready=1.
REQ-012 On accept in IDLE: data_in latched into shift register, bit counter loaded, next state SHIFT.
REQ-013 Latency: so SHALL equal data_in[WIDTH-1] in the first cycle after the accept edge, with frame=1.
REQ-014 SHIFT: each cycle presents the next lower bit; data bit k (MSB=0) appears in cycle k+1 after accept; exactly WIDTH data cycles.
REQ-015 ready SHALL be 0 during SHIFT except in the final frame cycle (last data bit, or parity bit when enabled), where ready=1.
REQ-016 valid while ready=0 SHALL be ignored; data_in changes during a frame SHALL NOT affect the frame in progress.
REQ-017 Accept in the final frame cycle: next frame's MSB on so in the immediately following cycle, frame stays 1, no idle gap.
REQ-018 No accept in the final frame cycle: next state IDLE; so=0 and frame=0 in the following cycle.
REQ-019 done SHALL be 1 exactly in the final frame cycle and 0 otherwise, including across back-to-back frames.
REQ-020 Bit counter width SHALL be $clog2(WIDTH+1); it SHALL NOT wrap or alias for any legal WIDTH.
REQ-021 Counter and FSM illegal states SHALL recover to IDLE on the next edge.

Reset
REQ-022 rst high at a clk edge: state IDLE, shift register 0, counter 0, so=0, frame=0, done=0.
REQ-023 ready SHALL be 0 while rst is high and 1 in the first cycle after rst is sampled low.
REQ-024 rst asserted mid-frame SHALL abort the frame; no remaining bits are sent and done SHALL NOT pulse.
REQ-025 valid asserted while rst is high SHALL NOT be accepted.

Configuration
REQ-026 Macro PISO_PARITY_EN defined: after the WIDTH data bits, one PAR cycle SHALL drive so = XOR of the latched word (even parity), frame=1. This PAR cycle is the final frame cycle and carries done and ready=1.
REQ-027 PISO_PARITY_EN undefined: no PAR state exists; the frame is WIDTH cycles, and the last data bit is the final frame cycle.

Verification
REQ-028 Reset, then accept 8'hA5 -> so = 1,0,1,0,0,1,0,1 in cycles 1..8 after accept; frame=1 cycles 1..8; done only in cycle 8; so=0 and frame=0 in cycle 9.
REQ-029 Accept 8'hA5, hold valid with 8'h3C through cycle 8 -> 3C accepted in cycle 8 only; so = 0,0,1,1,1,1,0,0 in cycles 9..16; frame continuously 1; done in cycles 8 and 16 only.
REQ-030 valid=1 with 8'hFF in cycles 2..7 of an 8'h00 frame -> ignored; so=0 for all 8 bits; ready=0 in cycles 1..7.
REQ-031 rst pulsed for one cycle after bit 3 of 8'hF0 -> so=0, frame=0, done=0 on the next edge; ready=1 the cycle after; no done for the aborted frame.
REQ-032 PISO_PARITY_EN defined: 8'hA5 -> 9-cycle frame with parity so=0 in cycle 9 and done in cycle 9. 8'h07 -> parity so=1.
REQ-033 valid held 0 for 20 cycles after reset -> so=0, frame=0, done=0, ready=1 throughout.
